// File: rtl/hqm_rcfwl_gclk_pkg.sv
// Shared types and widths for the regional gated-clock power-enable logic.
package hqm_rcfwl_gclk_pkg;

  localparam int RPEN_STATE_W = 2;
  localparam int STATS_CNT_W  = 16;

  typedef enum logic [RPEN_STATE_W-1:0] {
    RPEN_OFF  = 2'd0,
    RPEN_WAKE = 2'd1,
    RPEN_ON   = 2'd2,
    RPEN_HYST = 2'd3
  } rpen_state_t;

endpackage

// File: rtl/hqm_rcfwl_gclk_rpen_ctrl_if.sv
// Activity/config inputs and RPEn/ClkAck/debug outputs of the RPEn controller.
// Optional stats outputs exist only with HQM_RCFWL_GCLK_RPEN_STATS_EN defined.
interface hqm_rcfwl_gclk_rpen_ctrl_if
  import hqm_rcfwl_gclk_pkg::*;
#(
  parameter int HYST_W = 8
) ();

  logic                    ActiveReq;
  logic                    ForceOn;
  logic [HYST_W-1:0]       HystCfg;
  logic                    RPEn;
  logic                    ClkAck;
  logic [RPEN_STATE_W-1:0] CtrlState;
`ifdef HQM_RCFWL_GCLK_RPEN_STATS_EN
  logic [STATS_CNT_W-1:0]  GateCnt;
  logic [STATS_CNT_W-1:0]  WakeCnt;

  modport master (output ActiveReq, ForceOn, HystCfg,
                  input  RPEn, ClkAck, CtrlState, GateCnt, WakeCnt);
  modport slave  (input  ActiveReq, ForceOn, HystCfg,
                  output RPEn, ClkAck, CtrlState, GateCnt, WakeCnt);
`else
  modport master (output ActiveReq, ForceOn, HystCfg,
                  input  RPEn, ClkAck, CtrlState);
  modport slave  (input  ActiveReq, ForceOn, HystCfg,
                  output RPEn, ClkAck, CtrlState);
`endif

endinterface

// File: rtl/hqm_rcfwl_gclk_sat_cnt.sv
// Saturating up-counter: +1 per cycle while inc is high, sticks at all-ones.
module hqm_rcfwl_gclk_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hqm_rcfwl_gclk_rpen_ctrl.sv
// Regional RPEn controller: idle hysteresis, fixed wake latency, min-off guard; outputs registered.
// HQM_RCFWL_GCLK_RPEN_STATS_EN adds saturating GateCnt/WakeCnt transition counters.
module hqm_rcfwl_gclk_rpen_ctrl
  import hqm_rcfwl_gclk_pkg::*;
#(
  parameter int HYST_W   = 8,
  parameter int WAKE_LAT = 4,
  parameter int MIN_OFF  = 2,
  parameter int RESET_ON = 0
) (
  input  logic                        CkGridX1N,
  input  logic                        RstB,
  hqm_rcfwl_gclk_rpen_ctrl_if.slave   ctrl
);

  localparam rpen_state_t       RST_STATE = (RESET_ON != 0) ? RPEN_ON : RPEN_OFF;
  localparam logic [HYST_W-1:0] OFF_LD    = HYST_W'(MIN_OFF);
  localparam logic [HYST_W-1:0] WAKE_LD   = HYST_W'(WAKE_LAT - 1);
  localparam logic [HYST_W-1:0] RST_CNT   = (RESET_ON != 0) ? '0 : OFF_LD;
  localparam logic [HYST_W-1:0] ONE       = HYST_W'(1);

  rpen_state_t       state_q, state_nxt;
  logic [HYST_W-1:0] cnt_q, cnt_nxt;
  logic              rpen_q, ack_q;
  logic              want;

  assign want = ctrl.ActiveReq | ctrl.ForceOn;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      RPEN_OFF: begin
        // want is deliberately ignored until the min-off guard has drained
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - ONE;
        end else if (want) begin
          state_nxt = RPEN_WAKE;
          cnt_nxt   = WAKE_LD;
        end
      end
      RPEN_WAKE: begin
        if (cnt_q == '0) begin
          state_nxt = RPEN_ON;
        end else begin
          cnt_nxt = cnt_q - ONE;
        end
      end
      RPEN_ON: begin
        if (!want) begin
          if (ctrl.HystCfg != '0) begin
            state_nxt = RPEN_HYST;
            cnt_nxt   = ctrl.HystCfg - ONE;
          end else begin
            state_nxt = RPEN_OFF;
            cnt_nxt   = OFF_LD;
          end
        end
      end
      RPEN_HYST: begin
        if (want) begin
          state_nxt = RPEN_ON;
        end else if (cnt_q == '0) begin
          state_nxt = RPEN_OFF;
          cnt_nxt   = OFF_LD;
        end else begin
          cnt_nxt = cnt_q - ONE;
        end
      end
    endcase
  end

  always_ff @(posedge CkGridX1N or negedge RstB) begin
    if (!RstB) begin
      state_q <= RST_STATE;
      cnt_q   <= RST_CNT;
      rpen_q  <= (RESET_ON != 0);
      ack_q   <= (RESET_ON != 0);
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      rpen_q  <= (state_nxt != RPEN_OFF);
      ack_q   <= (state_nxt == RPEN_ON) || (state_nxt == RPEN_HYST);
    end
  end

  assign ctrl.RPEn      = rpen_q;
  assign ctrl.ClkAck    = ack_q;
  assign ctrl.CtrlState = state_q;

`ifdef HQM_RCFWL_GCLK_RPEN_STATS_EN
  logic gate_evt, wake_evt;

  assign gate_evt = ((state_q == RPEN_ON) || (state_q == RPEN_HYST)) && (state_nxt == RPEN_OFF);
  assign wake_evt = (state_q == RPEN_OFF) && (state_nxt == RPEN_WAKE);

  hqm_rcfwl_gclk_sat_cnt #(.W(STATS_CNT_W)) u_gate_cnt (
    .clk   (CkGridX1N),
    .rst_n (RstB),
    .inc   (gate_evt),
    .cnt   (ctrl.GateCnt)
  );

  hqm_rcfwl_gclk_sat_cnt #(.W(STATS_CNT_W)) u_wake_cnt (
    .clk   (CkGridX1N),
    .rst_n (RstB),
    .inc   (wake_evt),
    .cnt   (ctrl.WakeCnt)
  );
`endif

endmodule

// File: tb/tb_hqm_rcfwl_gclk_rpen_ctrl.sv
// Bench for hqm_rcfwl_gclk_rpen_ctrl: directed vector table, async-reset cases, randomized run vs timing model.
module tb_hqm_rcfwl_gclk_rpen_ctrl;

  localparam int HW = 8;
  localparam int WL = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_on_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hqm_rcfwl_gclk_rpen_ctrl_if #(.HYST_W(HW)) bus ();
  hqm_rcfwl_gclk_rpen_ctrl_if #(.HYST_W(HW)) bus_on ();

  hqm_rcfwl_gclk_rpen_ctrl #(.HYST_W(HW), .WAKE_LAT(WL), .MIN_OFF(MO), .RESET_ON(0)) u_dut (
    .CkGridX1N (clk),
    .RstB      (rst_n),
    .ctrl      (bus.slave)
  );

  hqm_rcfwl_gclk_rpen_ctrl #(.HYST_W(HW), .WAKE_LAT(WL), .MIN_OFF(MO), .RESET_ON(1)) u_dut_on (
    .CkGridX1N (clk),
    .RstB      (rst_on_n),
    .ctrl      (bus_on.slave)
  );

  typedef struct {
    logic          act;
    logic          frc;
    logic [HW-1:0] h;
    logic          rpen;
    logic          ack;
    logic [1:0]    st;
  } vec_t;

  vec_t tbl[$];

  // Reference model in terms of elapsed times: 0 dark, 1 waking, 2 clock running
  int m_mode, m_toff, m_twake, m_idle, m_hold, m_gates, m_wakes;

  task automatic add(input logic a, input logic f, input int h, input logic rp, input logic ak, input int st);
    vec_t v;
    v.act = a; v.frc = f; v.h = HW'(h); v.rpen = rp; v.ack = ak; v.st = 2'(st);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic f, input int h);
    bus.ActiveReq = a;
    bus.ForceOn   = f;
    bus.HystCfg   = HW'(h);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_toff = 0; m_twake = 0; m_idle = 0; m_hold = 0; m_gates = 0; m_wakes = 0;
  endtask

  task automatic model_go_off();
    m_mode = 0; m_toff = 0; m_idle = 0; m_gates++;
  endtask

  task automatic model_step(input bit want, input int h);
    case (m_mode)
      0: if (want && m_toff >= MO) begin
           m_mode = 1; m_twake = 0; m_wakes++;
         end else begin
           m_toff++;
         end
      1: begin
           m_twake++;
           if (m_twake == WL) begin m_mode = 2; m_idle = 0; end
         end
      default: begin
        if (want) m_idle = 0;
        else if (m_idle == 0 && h == 0) model_go_off();
        else if (m_idle == 0) begin m_hold = h; m_idle = 1; end
        else if (m_idle == m_hold) model_go_off();
        else m_idle++;
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    int exp_st;
    exp_st = (m_mode == 2) ? ((m_idle == 0) ? 2 : 3) : m_mode;
    chk({tag, "_rpen"}, 16'(bus.RPEn), 16'(m_mode != 0));
    chk({tag, "_ack"},  16'(bus.ClkAck), 16'(m_mode == 2));
    chk({tag, "_state"}, 16'(bus.CtrlState), 16'(exp_st));
    chk({tag, "_ack_implies_rpen"}, 16'(!(bus.ClkAck && !bus.RPEn)), 16'd1);
  endtask

  initial begin
    bit seen_on;
    bit a, f;
    int h;

    bus.ActiveReq = 1'b0;
    bus.ForceOn   = 1'b0;
    bus.HystCfg   = '0;
    bus_on.ActiveReq = 1'b0;
    bus_on.ForceOn   = 1'b1;
    bus_on.HystCfg   = '0;

    // act frc h  rpen ack st
    add(0,0,5, 0,0,0); add(0,0,5, 0,0,0); add(1,0,5, 1,0,1); add(0,0,5, 1,0,1);
    add(0,0,5, 1,0,1); add(0,0,5, 1,0,1); add(0,0,5, 1,1,2); add(0,0,5, 1,1,3);
    add(0,0,5, 1,1,3); add(0,0,5, 1,1,3); add(0,0,5, 1,1,3); add(0,0,5, 1,1,3);
    add(0,0,5, 0,0,0); add(1,0,5, 0,0,0); add(1,0,5, 0,0,0); add(1,0,5, 1,0,1);
    add(1,0,5, 1,0,1); add(1,0,5, 1,0,1); add(1,0,5, 1,0,1); add(1,0,5, 1,1,2);
    add(0,0,2, 1,1,3); add(0,0,7, 1,1,3); add(1,0,7, 1,1,2); add(0,0,0, 0,0,0);
    add(0,1,0, 0,0,0); add(0,1,0, 0,0,0); add(0,1,0, 1,0,1); add(0,1,0, 1,0,1);
    add(0,1,0, 1,0,1); add(0,1,0, 1,0,1); add(0,1,0, 1,1,2); add(0,0,0, 0,0,0);

    do_reset();
    chk("reset_rpen", 16'(bus.RPEn), 16'd0);
    chk("reset_ack", 16'(bus.ClkAck), 16'd0);
    chk("reset_state", 16'(bus.CtrlState), 16'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].act, tbl[i].frc, int'(tbl[i].h));
      step();
      chk($sformatf("row%0d_rpen", i + 1), 16'(bus.RPEn), 16'(tbl[i].rpen));
      chk($sformatf("row%0d_ack", i + 1), 16'(bus.ClkAck), 16'(tbl[i].ack));
      chk($sformatf("row%0d_state", i + 1), 16'(bus.CtrlState), 16'(tbl[i].st));
    end
`ifdef HQM_RCFWL_GCLK_RPEN_STATS_EN
    chk("tbl_gate_cnt", bus.GateCnt, 16'd3);
    chk("tbl_wake_cnt", bus.WakeCnt, 16'd3);
`endif

    // Async reset in the middle of WAKE
    do_reset();
    drive(1'b1, 1'b0, 3);
    repeat (4) step();
    chk("midwake_state", 16'(bus.CtrlState), 16'd1);
`ifdef HQM_RCFWL_GCLK_RPEN_STATS_EN
    chk("midwake_wake_cnt", bus.WakeCnt, 16'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rpen", 16'(bus.RPEn), 16'd0);
    chk("async_rst_ack", 16'(bus.ClkAck), 16'd0);
    chk("async_rst_state", 16'(bus.CtrlState), 16'd0);
`ifdef HQM_RCFWL_GCLK_RPEN_STATS_EN
    chk("async_rst_gate_cnt", bus.GateCnt, 16'd0);
    chk("async_rst_wake_cnt", bus.WakeCnt, 16'd0);
`endif

    // ForceOn held, ActiveReq random
    do_reset();
    model_reset();
    seen_on = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      a = 1'($urandom_range(0, 1));
      h = $urandom_range(0, 6);
      drive(a, 1'b1, h);
      model_step(1'b1, h);
      step();
      check_model("force");
      if (seen_on) chk("force_rpen_held", 16'(bus.RPEn), 16'd1);
      if (bus.RPEn) seen_on = 1'b1;
    end

    // Fully random activity with idle runs long enough to expire hysteresis
    do_reset();
    model_reset();
    a = 1'b0; f = 1'b0; h = 3;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      if ($urandom_range(0, 63) == 0) f = ~f;
      if ($urandom_range(0, 15) == 0) h = $urandom_range(0, 6);
      drive(a, f, h);
      model_step(a | f, h);
      step();
      check_model("rand");
    end
`ifdef HQM_RCFWL_GCLK_RPEN_STATS_EN
    chk("rand_gate_cnt", bus.GateCnt, 16'(m_gates));
    chk("rand_wake_cnt", bus.WakeCnt, 16'(m_wakes));
`endif

    // Reset-to-ON variant
    rst_on_n = 1'b0;
    step();
    rst_on_n = 1'b1;
    chk("rston_rpen", 16'(bus_on.RPEn), 16'd1);
    chk("rston_ack", 16'(bus_on.ClkAck), 16'd1);
    chk("rston_state", 16'(bus_on.CtrlState), 16'd2);
    step();
    chk("rston_hold_state", 16'(bus_on.CtrlState), 16'd2);
    bus_on.ForceOn = 1'b0;
    step();
    chk("rston_off_rpen", 16'(bus_on.RPEn), 16'd0);
    chk("rston_off_ack", 16'(bus_on.ClkAck), 16'd0);
    chk("rston_off_state", 16'(bus_on.CtrlState), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
